// File: rtl/rr_arb_mux.sv
// N-channel round-robin arbiter feeding a single registered output word with valid/ready on both sides.
// Define ARB_MUX_HOLD_EN to add the in_hold port and burst locking onto one channel.
module rr_arb_mux #(
  parameter int DATA_BITS = 8,
  parameter int CHANNELS  = 4,
  parameter int SEL_BITS  = $clog2(CHANNELS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS-1:0]           in_valid,
  input  logic [CHANNELS*DATA_BITS-1:0] in_data,
  output logic [CHANNELS-1:0]           in_ready,
`ifdef ARB_MUX_HOLD_EN
  input  logic [CHANNELS-1:0]           in_hold,
`endif
  output logic                          out_valid,
  output logic [DATA_BITS-1:0]          out_data,
  output logic [SEL_BITS-1:0]           out_sel,
  input  logic                          out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e                state_q;
  logic [DATA_BITS-1:0]  out_data_q;
  logic [SEL_BITS-1:0]   out_sel_q;
  logic [SEL_BITS-1:0]   last_grant_q;
`ifdef ARB_MUX_HOLD_EN
  logic                  lock_q;
  logic [SEL_BITS-1:0]   lock_ch_q;
`endif

  logic [DATA_BITS-1:0]  chan_data [CHANNELS];
  logic [CHANNELS-1:0]   req;
  logic [SEL_BITS-1:0]   winner;
  logic                  found;
  logic                  load_en;
  logic                  transfer;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) chan_data[i] = in_data[i*DATA_BITS +: DATA_BITS];
  end

  // While a burst lock is held only the locked channel may compete.
  always_comb begin
    req = in_valid;
`ifdef ARB_MUX_HOLD_EN
    if (lock_q) req = in_valid & (CHANNELS'(1) << lock_ch_q);
`endif
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin : arbiter
    logic [SEL_BITS-1:0] idx;
    found  = 1'b0;
    winner = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = SEL_BITS'((int'(last_grant_q) + k) % CHANNELS);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign load_en  = (state_q == EMPTY) || out_ready;
  assign transfer = !reset && load_en && found;

  always_comb begin
    in_ready = '0;
    if (transfer) in_ready[winner] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      last_grant_q <= SEL_BITS'(CHANNELS - 1);
`ifdef ARB_MUX_HOLD_EN
      lock_q       <= 1'b0;
      lock_ch_q    <= '0;
`endif
    end else begin
      case (state_q)
        EMPTY:   if (transfer) state_q <= FULL;
        FULL:    if (!transfer && out_ready) state_q <= EMPTY;
        default: state_q <= EMPTY;
      endcase
      // A drain with no refill leaves the stale word and select in place.
      if (transfer) begin
        out_data_q   <= chan_data[winner];
        out_sel_q    <= winner;
        last_grant_q <= winner;
`ifdef ARB_MUX_HOLD_EN
        lock_q       <= in_hold[winner];
        lock_ch_q    <= winner;
`endif
      end
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: doc/rr_arb_mux.md
# rr_arb_mux

Parametrised N-channel registered multiplexer with round-robin arbitration and valid/ready handshaking on every input and on the output. It replaces fixed-width combinational selects wherever several producers share one consumer, such as register-file write-back and bus masters sharing a memory port. Arbitration and output buffering are built in, so the select no longer has to be driven externally.

## Interface
- DATA_BITS, 8, width of each data word
- CHANNELS, 4, number of input channels, at least 2
- SEL_BITS, $clog2(CHANNELS), width of out_sel (derived; do not override)
- clk  input  1  single clock for the block; all logic is on the rising edge
- reset  input  1  synchronous, active-high reset, sampled on the clk rising edge
- in_valid  input  CHANNELS  per-channel valid; bit i belongs to channel i
- in_data  input  CHANNELS*DATA_BITS  flattened input words; channel i occupies [i*DATA_BITS +: DATA_BITS]
- in_ready  output  CHANNELS  per-channel ready; combinational; at most one bit high in any cycle
- in_hold  input  CHANNELS  per-channel burst-lock request; present only with ARB_MUX_HOLD_EN
- out_valid  output  1  output register holds a word
- out_data  output  DATA_BITS  registered word
- out_sel  output  SEL_BITS  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts out_data this cycle

## Operation
- Output stage FSM with two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = !out_valid || out_ready.
- Arbiter:
  - last_grant register, reset value CHANNELS-1.
  - The search order is last_grant+1, last_grant+2, … modulo CHANNELS.
  - The first channel in that order with in_valid=1 wins.
- in_ready[i] = load_en && (winner == i).
- A transfer on channel i occurs when in_valid[i] && in_ready[i].
- Each transfer does three things:
  - out_data <= that channel's word and out_sel <= i.
  - The FSM enters or stays in FULL.
  - last_grant <= i.
- If out_ready=1 in FULL and no input is valid, the FSM goes to EMPTY. out_data and out_sel keep their stale values.
- Simultaneous drain and refill (FULL with out_ready=1 and any in_valid=1): the new word is loaded in the same cycle and out_valid stays 1, so there is no bubble.
- If load_en=0, all in_ready bits are 0 and last_grant is unchanged.
- Wrap-around: after channel CHANNELS-1 is granted, channel 0 has the highest priority.
- Fairness: no channel waits more than CHANNELS-1 transfers while it holds in_valid=1.
- The upstream valid/ready rule is the producer's responsibility: once in_valid is asserted it stays asserted, with data stable, until the transfer.
- out_valid never drops without out_ready=1.
- out_data and out_sel are stable while out_valid=1 && out_ready=0.

## Timing
- Reset values: out_valid=0, out_data=0, out_sel=0, last_grant=CHANNELS-1, lock cleared.
- During reset, in_ready is forced to 0.
- If reset is asserted while FULL, the held word is discarded and reset wins over any concurrent transfer.
- Latency is 1 cycle: a word accepted at edge N appears on out_data with out_valid=1 after edge N.
- Throughput is one word per cycle when out_ready is held at 1.
- in_ready depends combinationally on in_valid, out_valid, out_ready and the lock state. out_* are purely registered.

## Configuration
- Macro: ARB_MUX_HOLD_EN.
- When defined, the in_hold port exists and burst locking is enabled:
  - A transfer on channel i with in_hold[i]=1 sets lock and lock_ch=i.
  - While locked, only lock_ch can win. Other channels get in_ready=0 even if lock_ch is idle.
  - A transfer on lock_ch with in_hold=0 clears the lock; arbitration resumes from lock_ch+1.
  - Reset clears the lock.
- When undefined, the in_hold port is absent, no lock logic exists, and arbitration is pure round-robin.

## Test plan
- Reset, then all channels valid with out_ready=1 (CHANNELS=4, data 8'hA0 to 8'hA3) -> out_sel sequence 0,1,2,3,0 with matching out_data, out_valid high on every cycle from the first load.
- Only channel 2 valid, data 8'h5C, out_ready=0 for 3 cycles -> out_valid=1, out_data=8'h5C, out_sel=2 held stable; in_ready=0 throughout the stall; one transfer only.
- last_grant=3 with channels 0 and 3 valid -> channel 0 wins (wrap-around); on the next free cycle channel 3 wins.
- FULL with out_ready=1 and channel 1 valid in the same cycle -> new word loaded, out_valid stays 1 with no bubble. Next cycle with no inputs -> out_valid=0.
- Reset pulsed while FULL and channel 0 valid -> after the edge out_valid=0, out_data=0, no in_ready; afterwards channel 0 is granted first.
- With ARB_MUX_HOLD_EN: channel 1 sends 3 beats with in_hold=1,1,0 while channel 2 is valid throughout -> out_sel=1,1,1 then 2; channel 2 in_ready=0 during the burst.
